// File: rtl/m65c02_pfx_ctrl.sv
// M65C02A prefix sequencer: accumulates OAX/OAY/OSY prefix chains, applies the
// resulting register overrides to exactly one target instruction, and holds
// off interrupts while a chain or its target is in flight.
module m65c02_pfx_ctrl #(
    parameter logic [7:0]  OAX_OP  = 8'hFB,
    parameter logic [7:0]  OAY_OP  = 8'hEB,
    parameter logic [7:0]  OSY_OP  = 8'h8B,
    parameter int unsigned MAX_PFX = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rdy,
    input  logic       Dec,
    input  logic [7:0] IR,
    input  logic       Done,
    input  logic       Flush,
    output logic       Pfx,
    output logic       OAX,
    output logic       OAY,
    output logic       OSY,
    output logic       IntInh,
    output logic [1:0] PfxCnt,
    output logic       PfxErr
);

    localparam int unsigned CNT_W   = 2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PFX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PFX  = 2'd1,
        ST_ACT  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             p_oax, p_oay, p_osy;
    logic             p_oax_nxt, p_oay_nxt, p_osy_nxt;
    logic             oax_nxt, oay_nxt, osy_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;
    logic             take;

    // Prefix opcode detect; the core uses this to suppress normal execution
    assign Pfx = Dec & ((IR == OAX_OP) | (IR == OAY_OP) | (IR == OSY_OP));

    // State, pending and active override registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= ST_IDLE;
            p_oax  <= 1'b0;
            p_oay  <= 1'b0;
            p_osy  <= 1'b0;
            OAX    <= 1'b0;
            OAY    <= 1'b0;
            OSY    <= 1'b0;
            PfxCnt <= '0;
            PfxErr <= 1'b0;
            IntInh <= 1'b0;
        end else begin
            state  <= state_nxt;
            p_oax  <= p_oax_nxt;
            p_oay  <= p_oay_nxt;
            p_osy  <= p_osy_nxt;
            OAX    <= oax_nxt;
            OAY    <= oay_nxt;
            OSY    <= osy_nxt;
            PfxCnt <= cnt_nxt;
            PfxErr <= err_nxt;
            IntInh <= (state_nxt != ST_IDLE);
        end
    end

    // Next-state: chain accumulation, target hand-off, release on Done
    always_comb begin
        state_nxt = state;
        p_oax_nxt = p_oax;
        p_oay_nxt = p_oay;
        p_osy_nxt = p_osy;
        oax_nxt   = OAX;
        oay_nxt   = OAY;
        osy_nxt   = OSY;
        cnt_nxt   = PfxCnt;
        err_nxt   = 1'b0;
        take      = 1'b0;

        if (Flush) begin
            state_nxt = ST_IDLE;
            p_oax_nxt = 1'b0;
            p_oay_nxt = 1'b0;
            p_osy_nxt = 1'b0;
            oax_nxt   = 1'b0;
            oay_nxt   = 1'b0;
            osy_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else if (Rdy) begin
            case (state)
                ST_IDLE: begin
                    take = Pfx;
                end
                ST_PFX: begin
                    if (Pfx) begin
                        if (PfxCnt < MAX_CNT) take = 1'b1;
                        else                  err_nxt = 1'b1;
                    end else if (Dec) begin
                        oax_nxt   = p_oax;
                        oay_nxt   = p_oay;
                        osy_nxt   = p_osy;
                        p_oax_nxt = 1'b0;
                        p_oay_nxt = 1'b0;
                        p_osy_nxt = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = ST_ACT;
                    end
                end
                ST_ACT: begin
                    // Pending bits and count are already clear here, so a
                    // back-to-back prefix starts a fresh chain from zero
                    if (Done) begin
                        oax_nxt   = 1'b0;
                        oay_nxt   = 1'b0;
                        osy_nxt   = 1'b0;
                        state_nxt = ST_IDLE;
                        take      = Pfx;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            // Accept a prefix: OAX/OAY are mutually exclusive, last one wins
            if (take) begin
                state_nxt = ST_PFX;
                cnt_nxt   = CNT_W'(cnt_nxt + CNT_W'(1));
                if (IR == OAX_OP) begin
                    p_oax_nxt = 1'b1;
                    p_oay_nxt = 1'b0;
                end
                if (IR == OAY_OP) begin
                    p_oay_nxt = 1'b1;
                    p_oax_nxt = 1'b0;
                end
                if (IR == OSY_OP) p_osy_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m65c02_pfx_ctrl.sv
// Bench for m65c02_pfx_ctrl: directed test-plan scenarios plus randomized
// traffic, checked every cycle against a chain-list reference model.
module tb_m65c02_pfx_ctrl;

    localparam int MAX_PFX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b0;
    logic       dec = 1'b0;
    logic [7:0] ir  = 8'h00;
    logic       done = 1'b0;
    logic       flush = 1'b0;
    logic       pfx, oax, oay, osy, int_inh, pfx_err;
    logic [1:0] pfx_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: list of accepted prefixes plus the active override set
    logic [7:0] chain[$];
    bit         m_active;
    bit         m_oax, m_oay, m_osy, m_err;

    m65c02_pfx_ctrl #(
        .OAX_OP(8'hFB), .OAY_OP(8'hEB), .OSY_OP(8'h8B), .MAX_PFX(MAX_PFX)
    ) dut (
        .Clk(clk), .Rst(rst), .Rdy(rdy), .Dec(dec), .IR(ir), .Done(done),
        .Flush(flush), .Pfx(pfx), .OAX(oax), .OAY(oay), .OSY(osy),
        .IntInh(int_inh), .PfxCnt(pfx_cnt), .PfxErr(pfx_err)
    );

    always #5 clk = ~clk;

    function automatic bit is_prefix(input logic [7:0] op);
        return (op == 8'hFB) || (op == 8'hEB) || (op == 8'h8B);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        chain.delete();
        m_active = 1'b0;
        m_oax = 1'b0; m_oay = 1'b0; m_osy = 1'b0; m_err = 1'b0;
    endtask

    // Model the effect of one rising edge given the inputs held across it
    task automatic model_edge();
        bit ip;
        int last_x, last_y;
        ip = dec && is_prefix(ir);
        m_err = 1'b0;
        if (flush) begin
            model_clear();
        end else if (rdy) begin
            if (m_active) begin
                if (done) begin
                    m_active = 1'b0;
                    m_oax = 1'b0; m_oay = 1'b0; m_osy = 1'b0;
                    if (ip) chain.push_back(ir);
                end
            end else if (chain.size() > 0) begin
                if (ip) begin
                    if (chain.size() < MAX_PFX) chain.push_back(ir);
                    else m_err = 1'b1;
                end else if (dec) begin
                    last_x = -1; last_y = -1;
                    m_osy = 1'b0;
                    foreach (chain[i]) begin
                        if (chain[i] == 8'hFB) last_x = i;
                        if (chain[i] == 8'hEB) last_y = i;
                        if (chain[i] == 8'h8B) m_osy = 1'b1;
                    end
                    m_oax = (last_x >= 0) && (last_x > last_y);
                    m_oay = (last_y >= 0) && (last_y > last_x);
                    m_active = 1'b1;
                    chain.delete();
                end
            end else if (ip) begin
                chain.push_back(ir);
            end
        end
    endtask

    // Compare every registered output against the model
    task automatic check_all();
        check("oax", {7'd0, oax}, {7'd0, m_oax});
        check("oay", {7'd0, oay}, {7'd0, m_oay});
        check("osy", {7'd0, osy}, {7'd0, m_osy});
        check("int_inh", {7'd0, int_inh}, {7'd0, (m_active || chain.size() > 0)});
        check("pfx_cnt", {6'd0, pfx_cnt}, 8'(chain.size()));
        check("pfx_err", {7'd0, pfx_err}, {7'd0, m_err});
        check("oax_oay_excl", {7'd0, oax & oay}, 8'd0);
    endtask

    // One cycle: drive at negedge, check Pfx, advance model at posedge, check at negedge
    task automatic step(input logic d, input logic [7:0] op, input logic r,
                        input logic dn, input logic fl);
        dec = d; ir = op; rdy = r; done = dn; flush = fl;
        #1;
        check("pfx", {7'd0, pfx}, {7'd0, (d && is_prefix(op))});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_oax", {7'd0, oax}, 8'd0);
        check("rst_oay", {7'd0, oay}, 8'd0);
        check("rst_osy", {7'd0, osy}, 8'd0);
        check_all();
        check("pfx_in_rst", {7'd0, pfx}, {7'd0, (dec && is_prefix(ir))});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Non-prefix decode while idle
        step(1, 8'hA9, 1, 0, 0);
        check("idle_inh", {7'd0, int_inh}, 8'd0);

        // FB then target 8A, Done two cycles later
        step(1, 8'hFB, 1, 0, 0);
        check("fb_inh", {7'd0, int_inh}, 8'd1);
        step(1, 8'h8A, 1, 0, 0);
        check("fb_oax", {7'd0, oax}, 8'd1);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 1, 0);
        check("done_oax", {7'd0, oax}, 8'd0);
        check("done_inh", {7'd0, int_inh}, 8'd0);

        // Full chain FB EB 8B then target 98
        step(1, 8'hFB, 1, 0, 0);
        step(1, 8'hEB, 1, 0, 0);
        step(1, 8'h8B, 1, 0, 0);
        check("chain_cnt3", {6'd0, pfx_cnt}, 8'd3);
        step(1, 8'h98, 1, 0, 0);
        check("chain_cnt0", {6'd0, pfx_cnt}, 8'd0);
        check("chain_oax", {7'd0, oax}, 8'd0);
        check("chain_oay", {7'd0, oay}, 8'd1);
        check("chain_osy", {7'd0, osy}, 8'd1);
        step(0, 8'h00, 1, 1, 0);

        // Overflow: fourth prefix rejected
        step(1, 8'hFB, 1, 0, 0);
        step(1, 8'hFB, 1, 0, 0);
        step(1, 8'hFB, 1, 0, 0);
        step(1, 8'hEB, 1, 0, 0);
        check("ovf_err", {7'd0, pfx_err}, 8'd1);
        step(0, 8'h00, 1, 0, 0);
        check("ovf_err_pulse", {7'd0, pfx_err}, 8'd0);
        step(1, 8'h98, 1, 0, 0);
        check("ovf_oax", {7'd0, oax}, 8'd1);
        check("ovf_oay", {7'd0, oay}, 8'd0);

        // Done coincident with a new prefix
        step(1, 8'hEB, 1, 1, 0);
        check("b2b_oax", {7'd0, oax}, 8'd0);
        check("b2b_cnt", {6'd0, pfx_cnt}, 8'd1);
        check("b2b_inh", {7'd0, int_inh}, 8'd1);
        step(1, 8'h98, 1, 0, 0);
        check("b2b_oay", {7'd0, oay}, 8'd1);
        step(0, 8'h00, 1, 1, 0);

        // Rdy low holds, Flush clears, async Rst in ACT
        step(1, 8'hFB, 0, 0, 0);
        check("rdy0_inh", {7'd0, int_inh}, 8'd0);
        step(1, 8'hFB, 1, 0, 0);
        step(1, 8'hFB, 0, 0, 0);
        check("rdy0_cnt", {6'd0, pfx_cnt}, 8'd1);
        step(0, 8'h00, 0, 0, 1);
        check("flush_inh", {7'd0, int_inh}, 8'd0);
        check("flush_cnt", {6'd0, pfx_cnt}, 8'd0);
        step(1, 8'h8B, 1, 0, 0);
        step(1, 8'h8A, 1, 0, 0);
        check("pre_rst_osy", {7'd0, osy}, 8'd1);
        async_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] op;
            case ($urandom_range(0, 6))
                0: op = 8'hFB;
                1: op = 8'hEB;
                2: op = 8'h8B;
                3: op = 8'h98;
                4: op = 8'hA9;
                default: op = 8'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) async_reset();
            step($urandom_range(0, 9) < 6, op, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
